// File: rtl/suc_pkg.sv
// Shared types and constants for the serial compare controller.
// Holds the FSM state encoding, the sticky bit-core encoding and the
// legal WIDTH bounds.
package suc_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COMPARE = 2'b01,
      DONE    = 2'b10
   } fsm_state_t;

   typedef enum logic [1:0] {
      CORE_EQ = 2'b00,
      CORE_GT = 2'b01,
      CORE_LT = 2'b10
   } core_state_t;

   // Map the core state onto the {L,E,G} result flags.
   function automatic logic [2:0] core_to_leg(input core_state_t s);
      logic [2:0] leg;
      leg = 3'b010;
      case (s)
         CORE_LT: leg = 3'b100;
         CORE_GT: leg = 3'b001;
         default: leg = 3'b010;
      endcase
      return leg;
   endfunction

endpackage

// File: rtl/suc_bit_core.sv
// Sticky one-bit magnitude comparator core.
// Consumes one (a,b) bit pair per enabled cycle, MSB first; the first
// differing pair decides GT or LT and later bits are ignored until clr.
module suc_bit_core
   import suc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        a_bit,
   input  logic        b_bit,
   input  logic        clr,
   input  logic        en,
   output core_state_t core_st
);

   // Sticky core state: leaves EQ on the first differing bit pair only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_st <= CORE_EQ;
      end else if (clr) begin
         core_st <= CORE_EQ;
      end else if (en && (core_st == CORE_EQ)) begin
         if (a_bit && !b_bit) begin
            core_st <= CORE_GT;
         end else if (!a_bit && b_bit) begin
            core_st <= CORE_LT;
         end
      end
   end

endmodule

// File: rtl/serial_compare_controller.sv
// Bit-serial unsigned magnitude comparator with valid/ready handshakes.
// Operands are shifted MSB first through suc_bit_core; the result is held
// on L/E/G with out_valid until the consumer takes it.
// Optional macro SUC_EARLY_EXIT_EN: finish as soon as the first differing
// bit is seen instead of always walking all WIDTH bits.
// WIDTH is legal over suc_pkg::WIDTH_MIN..WIDTH_MAX.
module serial_compare_controller
   import suc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             L,
   output logic             E,
   output logic             G,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   fsm_state_t       state;
   fsm_state_t       state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CNT_W-1:0] cnt;
   core_state_t      core_st;
   logic             accept;
   logic             core_en;
   logic             a_bit;
   logic             b_bit;

   assign a_bit = a_sh[WIDTH-1];
   assign b_bit = b_sh[WIDTH-1];

   suc_bit_core u_core (
      .clk     (clk),
      .rst     (rst),
      .a_bit   (a_bit),
      .b_bit   (b_bit),
      .clr     (accept),
      .en      (core_en),
      .core_st (core_st)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake/result decode; results are driven only in DONE.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      core_en   = 1'b0;
      L         = 1'b0;
      E         = 1'b0;
      G         = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = COMPARE;
            end
         end
         COMPARE: begin
            busy    = 1'b1;
            core_en = 1'b1;
            // The counter never wraps: reaching 0 means bit 0 is being consumed now.
            if (cnt == '0) begin
               state_nxt = DONE;
            end
`ifdef SUC_EARLY_EXIT_EN
            // The core leaves EQ on this edge, so the answer is already decided.
            else if (a_bit != b_bit) begin
               state_nxt = DONE;
            end
`endif
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            {L, E, G} = core_to_leg(core_st);
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand shift registers and bit counter: load on accept, shift MSB-first in COMPARE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_sh <= '0;
         b_sh <= '0;
         cnt  <= '0;
      end else if (accept) begin
         a_sh <= a_in;
         b_sh <= b_in;
         cnt  <= CNT_W'(WIDTH - 1);
      end else if (state == COMPARE) begin
         a_sh <= {a_sh[WIDTH-2:0], 1'b0};
         b_sh <= {b_sh[WIDTH-2:0], 1'b0};
         if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule
